mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the multi-cycle CPU's data-memory port: turns one load/store request from the
//  control unit into RD/WR strobes, a word address and write data for the byte-addressed big-endian
//  data memory, and returns the aligned, extended load result.
//  Byte and halfword stores run as read-modify-write; misaligned or out-of-range accesses are refused.
// PARAMETERS
//  MEM_BYTES  128  size of the attached data memory in bytes; must be a multiple of 4
// PORTS
//  CLK        in   1   system clock, rising edge
//  Reset      in   1   asynchronous, active-high reset
//  start      in   1   request strobe; sampled only in IDLE
//  op_we      in   1   1 = store, 0 = load
//  size       in   2   00 byte, 01 halfword, 10 word, 11 illegal
//  sign_ext   in   1   loads: 1 sign-extends, 0 zero-extends (ignored for word and store)
//  addr       in   32  byte address of the access
//  wdata      in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  busy       out  1   high from the cycle after start is accepted until done
//  done       out  1   one-cycle completion pulse
//  error      out  1   valid with done: 1 = access refused, no memory strobe issued
//  rdata      out  32  load result; updated only when a load completes without error
//  mem_rd     out  1   memory read strobe
//  mem_wr     out  1   memory write strobe
//  mem_addr   out  32  word address to memory, always {A[31:2],2'b00}
//  mem_wdata  out  32  full word to write
//  mem_rdata  in   32  memory read data, combinational from mem_addr while mem_rd=1
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy, done, error, mem_rd, mem_wr=0; rdata, mem_addr, mem_wdata=0.
//    Reset mid-access drops strobes immediately; no done is produced for the aborted request.
//  - IDLE & start: latch op_we,size,sign_ext,addr,wdata into A/D registers; later start ignored while busy.
//  - States: IDLE, READ, WRITE, DONE. mem_rd=1 only in READ, mem_wr=1 only in WRITE, never both;
//    strobes and mem_addr decode from registers only (no combinational path from request inputs).
//  - Check in IDLE on accept: error if size=11, half with A[0]=1, word with A[1:0]!=0, or
//    {A[31:2],2'b00}+3 >= MEM_BYTES. Error -> DONE next cycle with error=1, no strobes.
//  - Load:          IDLE -> READ -> DONE. mem_rdata captured at the READ->DONE edge.
//  - Word store:    IDLE -> WRITE -> DONE. mem_wdata = D.
//  - Sub-word store: IDLE -> READ -> WRITE -> DONE; captured word merged with D's low lane(s), other bytes kept.
//  - Latency from start cycle T: error done at T+1; load and word store done at T+2; sub-word store done at T+3.
//  - Big-endian lanes: offset 0 = mem word [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0];
//    half at offset 0 = [31:16], offset 2 = [15:0].
//  - Load result: selected lane right-justified, extended to 32 bits per sign_ext; word unchanged.
//  - DONE: done=1, busy=0 for one cycle, then IDLE; start is accepted in the IDLE cycle after DONE.
//  - error holds its value until the next accept; rdata holds until the next successful load.
// TESTING
//  - Word store addr=0x10, wdata=0xDEADBEEF, then word load 0x10 -> one mem_wr at 0x10; done T+2; rdata=0xDEADBEEF
//  - Byte load addr=0x11, sign_ext=1 on that word -> rdata=0xFFFFFFAD; sign_ext=0 -> rdata=0x000000AD
//  - Byte store addr=0x12, wdata=0x00000055 -> READ then WRITE mem_wdata=0xDEAD55EF at 0x10; done T+3
//  - Half load addr=0x13 / word addr=0x7E / word addr=0x80 (MEM_BYTES=128) -> done T+1, error=1, no strobes
//  - start pulsed while busy -> ignored; Reset asserted in READ -> mem_rd=0 at once, no done, next start normal

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory initiator for the multi-cycle CPU: turns one load/store request into RD/WR strobes
// on a big-endian word-wide memory, merging sub-word stores by read-modify-write.
module mem_access_unit #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        op_we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] rdata_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    // state   | meaning
    // S_IDLE  | waiting for start, request checked on accept
    // S_READ  | mem_rd asserted, read word captured on exit
    // S_WRITE | mem_wr asserted with the full word
    // S_DONE  | one-cycle done pulse, error/rdata valid
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    state_t      state_q;
    logic        we_q, sext_q;
    logic [1:0]  size_q, offs_q;
    logic [15:0] data_q;
    logic        busy_q, done_q, error_q, mem_rd_q, mem_wr_q;
    logic [31:0] rdata_q, mem_addr_q, mem_wdata_q;

    logic [31:0] base_d, load_d, merge_d;
    logic        acc_err_d;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        base_d    = {addr_i[31:2], 2'b00};
        acc_err_d = (size_i == 2'b11)
                 || (size_i == 2'b01 && addr_i[0])
                 || (size_i == 2'b10 && addr_i[1:0] != 2'b00)
                 || (base_d + 32'd3 >= MEM_LIMIT);

        case (offs_q)
            2'd0:    byte_lane = mem_rdata_i[31:24];
            2'd1:    byte_lane = mem_rdata_i[23:16];
            2'd2:    byte_lane = mem_rdata_i[15:8];
            default: byte_lane = mem_rdata_i[7:0];
        endcase
        half_lane = offs_q[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];

        case (size_q)
            2'b00:   load_d = sext_q ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
            2'b01:   load_d = sext_q ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
            default: load_d = mem_rdata_i;
        endcase

        // Only the addressed lane(s) change; the rest of the word comes back as read.
        merge_d = mem_rdata_i;
        if (size_q == 2'b00) begin
            case (offs_q)
                2'd0:    merge_d[31:24] = data_q[7:0];
                2'd1:    merge_d[23:16] = data_q[7:0];
                2'd2:    merge_d[15:8]  = data_q[7:0];
                default: merge_d[7:0]   = data_q[7:0];
            endcase
        end else if (offs_q[1]) begin
            merge_d[15:0] = data_q;
        end else begin
            merge_d[31:16] = data_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            size_q      <= 2'b00;
            offs_q      <= 2'b00;
            data_q      <= 16'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            rdata_q     <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        we_q       <= op_we_i;
                        sext_q     <= sign_ext_i;
                        size_q     <= size_i;
                        offs_q     <= addr_i[1:0];
                        data_q     <= wdata_i[15:0];
                        mem_addr_q <= base_d;
                        error_q    <= acc_err_d;
                        if (acc_err_d) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (op_we_i && size_i == 2'b10) begin
                            mem_wdata_q <= wdata_i;
                            mem_wr_q    <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= S_WRITE;
                        end else begin
                            mem_rd_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    mem_rd_q <= 1'b0;
                    if (we_q) begin
                        mem_wdata_q <= merge_d;
                        mem_wr_q    <= 1'b1;
                        state_q     <= S_WRITE;
                    end else begin
                        rdata_q <= load_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_WRITE: begin
                    mem_wr_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign rdata_o     = rdata_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
